// File: rtl/inst_mem_responder_pkg.sv
// Shared CPU fetch-side definitions: bus widths, fetch state encoding and the NOP word.
// Imported by the instruction-memory responder and its program store.
package inst_mem_responder_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 32;
  localparam int LAT_CNT_W  = 4;

  localparam logic [CPU_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_mem_responder_inst_store.sv
// Program store: DEPTH x DATA_W array, one synchronous write port and one combinational read port.
// Kept on its own so it can be replaced by a memory macro.
module inst_mem_responder_inst_store
  import inst_mem_responder_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 2 ** CPU_ADDR_W
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [DATA_W-1:0] RDATA
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Program-store write port; contents are never cleared by reset.
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem_r[WADDR] <= WDATA;
    end
  end

  assign RDATA = mem_r[RADDR];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts a PC fetch, stalls the CPU with BUSYWAIT for a
// fixed latency, then returns the registered instruction with a one-cycle VALID pulse.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int DEPTH   = 2 ** CPU_ADDR_W,
  parameter int LATENCY = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic              READ,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              VALID,
  output logic              BUSYWAIT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [DATA_W-1:0] LOAD_DATA
);

  localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(LATENCY - 1);

  fetch_state_t          state_r, state_s;
  logic [LAT_CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0]     addr_r, addr_s;
  logic [DATA_W-1:0]     instr_r, instr_s;
  logic                  valid_r, valid_s;
  logic                  busy_r, busy_s;
  logic [DATA_W-1:0]     rd_data_s;

  inst_mem_responder_inst_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .CLK   (CLK),
    .WE    (LOAD_EN),
    .WADDR (LOAD_ADDR),
    .WDATA (LOAD_DATA),
    .RADDR (addr_r),
    .RDATA (rd_data_s)
  );

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    instr_s = instr_r;
    valid_s = 1'b0;
    busy_s  = busy_r;
    case (state_r)
      IDLE, DONE: begin
        if (READ) begin
          addr_s  = ADDRESS;
          cnt_s   = LAT_M1;
          busy_s  = 1'b1;
          state_s = WAIT;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      WAIT: begin
        // Capture reads the store before this edge's write lands (read-before-write).
        if (cnt_r == {LAT_CNT_W{1'b0}}) begin
          instr_s = rd_data_s;
          valid_s = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      cnt_r   <= {LAT_CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign INSTRUCTION = instr_r;
  assign VALID       = valid_r;
  assign BUSYWAIT    = busy_r;

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder on the fetch side of the 8-bit CPU.
- Takes the 8-bit PC value as a word address and returns the 32-bit instruction after a fixed multi-cycle latency.
- Holds the CPU off with BUSYWAIT while the access is in flight.
- Provides a load port so the bench or a boot loader can fill the program store.

Parameters:
ADDR_W, 8, address width; must match the PC width.
DATA_W, 32, instruction width.
DEPTH, 256, number of instruction words (2**ADDR_W).
LATENCY, 3, cycles from request acceptance to data return; legal range 1..15.

Ports:
CLK  input  1  single system clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
ADDRESS  input  ADDR_W  word address, driven from the program counter output.
READ  input  1  fetch request.
INSTRUCTION  output  DATA_W  registered instruction word.
VALID  output  1  one-cycle pulse when INSTRUCTION holds new data.
BUSYWAIT  output  1  registered; high while a fetch is outstanding; CPU must stall PC.
LOAD_EN  input  1  program-store write enable.
LOAD_ADDR  input  ADDR_W  program-store write address.
LOAD_DATA  input  DATA_W  program-store write data.

Behaviour:
- Reset: any edge with RESET=1 forces
  - state IDLE, latency counter 0, latched address 0;
  - INSTRUCTION=0, VALID=0, BUSYWAIT=0.
- The memory array is not cleared. RESET has priority over all other inputs and aborts any in-flight fetch without a VALID pulse.
- States: IDLE, WAIT, DONE.
- IDLE:
  - READ=1 at edge N: latch ADDRESS, load counter with LATENCY-1, go to WAIT.
  - BUSYWAIT=1 from edge N.
  - READ=0: stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0 (edge N+LATENCY): INSTRUCTION <= mem[latched address], VALID <= 1, BUSYWAIT <= 0, go to DONE.
  - ADDRESS and READ changes during WAIT are ignored.
- DONE: lasts one cycle, with VALID=1.
  - READ=1 at this edge: accept a back-to-back fetch exactly as in IDLE (go to WAIT, BUSYWAIT=1, VALID <= 0).
  - Otherwise VALID <= 0 and go to IDLE.
- LATENCY=1: WAIT is skipped. Acceptance at edge N; data, VALID=1 and BUSYWAIT=0 at edge N+1.
- INSTRUCTION holds its last value until the next capture and never changes outside a capture edge.
- Load port:
  - LOAD_EN=1 writes mem[LOAD_ADDR] <= LOAD_DATA at the edge, in every state, independent of READ.
  - Write to the in-flight address on the capture edge: the fetch returns the old word (read-before-write).
  - Write on any earlier edge of the fetch: the fetch returns the new word.
- Address arithmetic: none internally. The address wraps only as the PC wraps (0xFF -> 0x00); mem[0xFF] and mem[0x00] are both addressable.
- Throughput: one instruction per LATENCY+1 cycles with READ held high. Back-to-back through DONE gives one per LATENCY cycles plus the DONE cycle.

Decomposition:
- Shared CPU package holds:
  - ADDR_W and DATA_W constants, shared with programCounter and the register file;
  - the fetch state enum {IDLE, WAIT, DONE};
  - NOP instruction constant 32'h0000_0000, the reset value of INSTRUCTION.
- One natural sub-module, inst_store: DEPTH x DATA_W array with one synchronous write port and one combinational read port, kept separate so it can be swapped for a macro.
- The FSM and counter stay in the top module.

Test Plan:
1. Reset then idle: RESET=1 for 2 cycles, READ=0 for 5 cycles -> INSTRUCTION=0, VALID=0 and BUSYWAIT=0 on every cycle.
2. Single fetch, LATENCY=3: load mem[0x05]=32'hDEADBEEF, then READ=1 for one cycle at edge N with ADDRESS=0x05 -> BUSYWAIT high for edges N..N+2; at edge N+3 INSTRUCTION=32'hDEADBEEF, VALID=1 for one cycle, BUSYWAIT=0.
3. Sequential PC stream: load mem[0..3]=32'h11,22,33,44; hold READ=1, stepping ADDRESS 0->3 on each VALID -> VALID pulses every 4 cycles, returning 11,22,33,44 in order. Changing ADDRESS mid-WAIT to 0xAA has no effect.
4. Wrap: load mem[0xFF]=32'hFFFF0001 and mem[0x00]=32'h0000ABCD; fetch 0xFF then 0x00 -> both words returned correctly.
5. Reset mid-fetch: accept a fetch of 0x05, assert RESET at edge N+1 -> next cycle BUSYWAIT=0, state IDLE, no VALID pulse ever, INSTRUCTION=0.
6. Load collision: fetch 0x10 (old 32'hA) with LOAD_EN writing 32'hB to 0x10:
   - write at capture edge N+3 -> returns 32'hA;
   - repeat with the write at edge N+1 -> returns 32'hB.
